regfile_mp: RTL and testbench

Parametrised multi-read-port register file; successor to the single-pair integer regfile in the decode/execute stage. Configurable data width, depth and number of read ports, with registered (1-cycle) reads and per-port valid. After reset, an init sequencer clears storage one entry per cycle so the array can map to SRAM/LUTRAM without a wide reset.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_rd_port.sv | 64 ++++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, defaults and address helper for the multi-read-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NUM_RD_DEF = 2;

  typedef enum logic {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // True when the address names a real, writable register (not x0, not past the top).
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned nregs);
    return (addr != 32'd0) && (addr < nregs);
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address check, optional write-first bypass, rdata/valid flops.
// Bypass is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ready_i,
  input  logic            rd_en_i,
  input  logic [AW-1:0]   rd_addr_i,
  input  logic [XLEN-1:0] mem_rdata_i,
`ifdef REGFILE_BYPASS_EN
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
`endif
  output logic [XLEN-1:0] rdata_o,
  output logic            valid_o
);

  logic [XLEN-1:0] rdata_d, rdata_q;
  logic            valid_d, valid_q;
  logic            addr_ok_c;
  logic [XLEN-1:0] rd_word_c;

  assign addr_ok_c = addr_ok(32'(rd_addr_i), NREGS);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit_c;
  // Write address was range-checked by the read address compare plus addr_ok_c.
  assign bypass_hit_c = ready_i && wr_en_i && (wr_addr_i == rd_addr_i);
  assign rd_word_c    = !addr_ok_c   ? '0 :
                        bypass_hit_c ? wr_data_i : mem_rdata_i;
`else
  assign rd_word_c    = addr_ok_c ? mem_rdata_i : '0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    valid_d = 1'b0;
    if (ready_i && rd_en_i) begin
      rdata_d = rd_word_c;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      valid_q <= valid_d;
    end
  end

  assign rdata_o = rdata_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with storage array, write path and post-reset clear sequencer.
// Optional write-first forwarding on reads is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NUM_RD = NUM_RD_DEF,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD-1:0]      reg_rd_en_i,
  input  logic [NUM_RD*AW-1:0]   reg_rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] reg_rd_rdata_o,
  output logic [NUM_RD-1:0]      reg_rd_valid_o,
  input  logic                   reg_wr_en_i,
  input  logic [AW-1:0]          reg_wr_addr_i,
  input  logic [XLEN-1:0]        reg_wr_data_i,
  output logic                   init_done_o
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   init_ptr_q, init_ptr_d;
  logic            init_done_q, init_done_d;

  logic            mem_we_c;
  logic [AW-1:0]   mem_waddr_c;
  logic [XLEN-1:0] mem_wdata_c;
  logic            ready_c;

  logic [XLEN-1:0] mem_q [NREGS];

  assign ready_c = (state_q == RF_READY);

  // Init sequencer clears one entry per cycle; in READY the user write port owns the array.
  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    init_done_d = init_done_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = reg_wr_addr_i;
    mem_wdata_c = reg_wr_data_i;
    case (state_q)
      RF_INIT: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = init_ptr_q;
        mem_wdata_c = '0;
        if (init_ptr_q == AW'(NREGS - 1)) begin
          state_d     = RF_READY;
          init_done_d = 1'b1;
        end else begin
          init_ptr_d = init_ptr_q + AW'(1);
        end
      end
      RF_READY: begin
        mem_we_c = reg_wr_en_i && addr_ok(32'(reg_wr_addr_i), NREGS);
      end
      default: begin
        state_d = RF_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RF_INIT;
      init_ptr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage has no reset so it can map onto RAM macros; reset drops any write that cycle.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign init_done_o = init_done_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   addr_c;
    logic [XLEN-1:0] word_c;

    assign addr_c = reg_rd_addr_i[k*AW +: AW];
    assign word_c = (32'(addr_c) < NREGS) ? mem_q[addr_c] : '0;

    regfile_rd_port #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rd_port (
      .clk         (clk),
      .rst_n       (rst_n),
      .ready_i     (ready_c),
      .rd_en_i     (reg_rd_en_i[k]),
      .rd_addr_i   (addr_c),
      .mem_rdata_i (word_c),
`ifdef REGFILE_BYPASS_EN
      .wr_en_i     (reg_wr_en_i),
      .wr_addr_i   (reg_wr_addr_i),
      .wr_data_i   (reg_wr_data_i),
`endif
      .rdata_o     (reg_rd_rdata_o[k*XLEN +: XLEN]),
      .valid_o     (reg_rd_valid_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 32-entry instance plus a 24-entry one).
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rdata;
  logic [1:0]  valid;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        init_done;

  logic [1:0]  rd_en_b;
  logic [9:0]  rd_addr_b;
  logic [63:0] rdata_b;
  logic [1:0]  valid_b;
  logic        wr_en_b;
  logic [4:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic        init_done_b;

  int checks;
  int failures;

  regfile_mp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reg_rd_en_i    (rd_en),
    .reg_rd_addr_i  (rd_addr),
    .reg_rd_rdata_o (rdata),
    .reg_rd_valid_o (valid),
    .reg_wr_en_i    (wr_en),
    .reg_wr_addr_i  (wr_addr),
    .reg_wr_data_i  (wr_data),
    .init_done_o    (init_done)
  );

  regfile_mp #(.XLEN(32), .NREGS(24), .NUM_RD(2)) dut24 (
    .clk            (clk),
    .rst_n          (rst_n),
    .reg_rd_en_i    (rd_en_b),
    .reg_rd_addr_i  (rd_addr_b),
    .reg_rd_rdata_o (rdata_b),
    .reg_rd_valid_o (valid_b),
    .reg_wr_en_i    (wr_en_b),
    .reg_wr_addr_i  (wr_addr_b),
    .reg_wr_data_i  (wr_data_b),
    .init_done_o    (init_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = 2'b00; wr_en = 1'b0; rd_en_b = 2'b00; wr_en_b = 1'b0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Count cycles until init_done rises; reads and a write to x5 are held active throughout.
  task automatic run_init(output int cyc, output int bad_valid);
    cyc = 0; bad_valid = 0;
    rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    while (cyc < 64 && init_done !== 1'b1) begin
      tick();
      cyc++;
      if (valid !== 2'b00) bad_valid++;
    end
    idle();
  endtask

  task automatic test_reset();
    int cyc, bad;
    rst_n = 1'b0; idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    rd_addr_b = '0; wr_addr_b = '0; wr_data_b = '0;
    tick(); tick();
    checks++;
    if (init_done !== 1'b0 || valid !== 2'b00 || rdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_state done=%b valid=%b rdata=%h exp done=0 valid=00 rdata=0", init_done, valid, rdata);
    end
    rst_n = 1'b1;
    run_init(cyc, bad);
    checks++;
    if (cyc != 32) begin
      failures++;
      $display("FAIL init_len got=%0d exp=32", cyc);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL init_valid cycles_with_valid=%0d exp=0", bad);
    end
    checks++;
    if (init_done_b !== 1'b1) begin
      failures++;
      $display("FAIL init24_done got=%b exp=1", init_done_b);
    end
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick(); idle();
    checks++;
    if (valid !== 2'b01 || rdata[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL init_write_dropped valid=%b rdata=%h exp valid=01 rdata=0", valid, rdata[31:0]);
    end
  endtask

  task automatic test_rw();
    write(5'd7, 32'h1234_5678);
    checks++;
    if (valid !== 2'b00) begin
      failures++;
      $display("FAIL rw_pre_valid got=%b exp=00", valid);
    end
    rd_en = 2'b11; rd_addr = {5'd7, 5'd7};
    tick(); idle();
    checks++;
    if (valid !== 2'b11 || rdata !== {32'h1234_5678, 32'h1234_5678}) begin
      failures++;
      $display("FAIL rw_x7 valid=%b rdata=%h exp valid=11 rdata=1234567812345678", valid, rdata);
    end
  endtask

  task automatic test_addr_rules();
    write(5'd0, 32'hFFFF_FFFF);
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    tick(); idle();
    checks++;
    if (valid !== 2'b11 || rdata !== 64'h0) begin
      failures++;
      $display("FAIL x0_read valid=%b rdata=%h exp valid=11 rdata=0", valid, rdata);
    end
    wr_en_b = 1'b1; wr_addr_b = 5'd30; wr_data_b = 32'h1111_2222;
    tick();
    wr_addr_b = 5'd23; wr_data_b = 32'hCAFE_F00D;
    tick(); idle();
    rd_en_b = 2'b11; rd_addr_b = {5'd23, 5'd30};
    tick(); idle();
    checks++;
    if (valid_b !== 2'b11 || rdata_b[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL oor_read valid=%b rdata=%h exp valid=11 rdata=0", valid_b, rdata_b[31:0]);
    end
    checks++;
    if (rdata_b[63:32] !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL top_entry got=%h exp=cafef00d", rdata_b[63:32]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hA5A5_A5A5;
`else
    exp = 32'h0000_0001;
`endif
    write(5'd3, 32'h0000_0001);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    tick(); idle();
    checks++;
    if (rdata[31:0] !== exp) begin
      failures++;
      $display("FAIL same_cycle_rw got=%h exp=%h", rdata[31:0], exp);
    end
    rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
    tick(); idle();
    checks++;
    if (rdata[63:32] !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL after_write got=%h exp=a5a5a5a5", rdata[63:32]);
    end
  endtask

  task automatic test_hold();
    rd_en = 2'b11; rd_addr = {5'd3, 5'd7};
    tick();
    rd_en = 2'b00;
    checks++;
    if (valid !== 2'b11 || rdata !== {32'hA5A5_A5A5, 32'h1234_5678}) begin
      failures++;
      $display("FAIL indep_ports valid=%b rdata=%h exp valid=11 rdata=a5a5a5a512345678", valid, rdata);
    end
    tick();
    checks++;
    if (valid !== 2'b00 || rdata !== {32'hA5A5_A5A5, 32'h1234_5678}) begin
      failures++;
      $display("FAIL hold valid=%b rdata=%h exp valid=00 rdata=a5a5a5a512345678", valid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h0000_0011; exp_tab[1] = 32'h0000_0022;
    exp_tab[2] = 32'h0000_0033; exp_tab[3] = 32'h0000_0044;
    for (int i = 0; i < 4; i++) write(5'(i + 10), exp_tab[i]);
    for (int i = 0; i < 4; i++) begin
      rd_en = 2'b01; rd_addr = {5'd0, 5'(i + 10)};
      tick();
      checks++;
      if (valid[0] !== 1'b1 || rdata[31:0] !== exp_tab[i]) begin
        failures++;
        $display("FAIL b2b_%0d valid=%b rdata=%h exp valid=1 rdata=%h", i, valid[0], rdata[31:0], exp_tab[i]);
      end
    end
    idle();
  endtask

  task automatic test_midreset();
    int cyc, bad;
    write(5'd9, 32'h0000_0055);
    rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    tick(); idle();
    checks++;
    if (rdata[31:0] !== 32'h0000_0055) begin
      failures++;
      $display("FAIL pre_reset_x9 got=%h exp=55", rdata[31:0]);
    end
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h7777_7777;
    tick(); idle();
    checks++;
    if (init_done !== 1'b0 || valid !== 2'b00 || rdata !== 64'h0) begin
      failures++;
      $display("FAIL midreset_state done=%b valid=%b rdata=%h exp done=0 valid=00 rdata=0", init_done, valid, rdata);
    end
    rst_n = 1'b1;
    run_init(cyc, bad);
    checks++;
    if (cyc != 32 || bad != 0) begin
      failures++;
      $display("FAIL reinit_len got=%0d bad_valid=%0d exp=32 bad_valid=0", cyc, bad);
    end
    rd_en = 2'b11; rd_addr = {5'd12, 5'd9};
    tick(); idle();
    checks++;
    if (valid !== 2'b11 || rdata !== 64'h0) begin
      failures++;
      $display("FAIL post_reset_clear valid=%b rdata=%h exp valid=11 rdata=0", valid, rdata);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_rw();
    test_addr_rules();
    test_bypass();
    test_hold();
    test_back_to_back();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
